router_ctrl: RTL and testbench
==============================

ROUTER_CTRL -- requirements
Module: router_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port: pkt_valid  in  1  high for header and payload bytes; low on the parity byte.
REQ-004 SHALL have port: din  in  8  byte from source (header, payload or parity).
REQ-005 SHALL have ports: fifo_full  in  3  and  fifo_empty  in  3  status of the three output FIFOs, bit i = FIFO i.
REQ-006 SHALL have port: rd_en  in  3  downstream read strobes of the three FIFOs.
REQ-007 SHALL have ports: wr_en  out  3  one-hot FIFO write enables; dout  out  8  byte to FIFO din; lfd_state  out  1  first-byte (header) tag.
REQ-008 SHALL have ports: busy  out  1  source stall, source holds din while high; parity_err  out  1  one-cycle error pulse; soft_rst  out  3  per-FIFO soft-reset pulses.

Function
REQ-009 SHALL frame packets as: header (din[1:0] = address 0..2, din[7:2] = payload length), payload bytes, then one parity byte = XOR of header and all payload bytes.
REQ-010 SHALL implement states DECODE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, FIFO_FULL, CHECK_PARITY.
REQ-011 DECODE: busy=0; on pkt_valid with din[1:0]!=3, latch address and header byte, init parity=header, then go LOAD_FIRST if fifo_empty[addr], else WAIT_EMPTY.
REQ-012 DECODE: pkt_valid with din[1:0]==3 SHALL be discarded; stay in DECODE, no write.
REQ-013 WAIT_EMPTY: busy=1, no write; go LOAD_FIRST in the cycle after fifo_empty[addr] is seen high.
REQ-014 LOAD_FIRST: busy=1, wr_en[addr]=1, dout=latched header, lfd_state=1; next state LOAD_DATA.
REQ-015 LOAD_DATA, fifo_full[addr]=0, pkt_valid=1: busy=0, wr_en[addr]=1, dout=din, parity^=din; stay.
REQ-016 LOAD_DATA, fifo_full[addr]=0, pkt_valid=0: wr_en[addr]=1, dout=din (parity byte), latch din as received parity; go CHECK_PARITY.
REQ-017 LOAD_DATA with fifo_full[addr]=1: busy=1 combinationally, no write, no parity update; go FIFO_FULL.
REQ-018 FIFO_FULL: busy=1, no write; return to LOAD_DATA when fifo_full[addr]=0; held byte is written there.
REQ-019 CHECK_PARITY: busy=1, no write; parity_err=1 for this cycle iff computed != received parity; go DECODE.
REQ-020 wr_en, dout, lfd_state and busy SHALL be combinational from state and inputs (zero-latency write on the FSM edge); wr_en at most one bit set; wr_en=0, dout=0, lfd_state=0 outside REQ-014..016 write conditions.
REQ-021 Write enables SHALL never assert while fifo_full[addr]=1.
REQ-022 If soft_rst[addr] pulses in WAIT_EMPTY, LOAD_FIRST, LOAD_DATA or FIFO_FULL, FSM SHALL abort to DECODE next cycle with no write that cycle and no parity_err.

Reset
REQ-023 rst=0 at a rising edge SHALL force state DECODE, address 0, parity and received-parity registers 0, timeout counters 0; outputs wr_en=0, dout=0, lfd_state=0, busy=0, parity_err=0, soft_rst=0 from that edge, regardless of current state.

Configuration
REQ-024 Macro SOFT_RST_TIMEOUT_EN defined: per FIFO i, 5-bit counter increments each cycle fifo_empty[i]=0 and rd_en[i]=0, clears on rd_en[i]=1 or fifo_empty[i]=1; on 30th consecutive counted cycle soft_rst[i]=1 for one cycle and counter clears.
REQ-025 Macro SOFT_RST_TIMEOUT_EN undefined: no counters, soft_rst tied to 3'b000, REQ-022 inert.

Verification
REQ-026 Header 8'h0D (addr 1, len 3), payload 11,22,33, parity 8'h0D^11^22^33=8'h0D, FIFO1 empty -> wr_en=3'b010 for 5 writes, lfd_state=1 only on header, parity_err=0.
REQ-027 Same packet with parity byte 8'hFF -> all 5 bytes written, parity_err=1 for exactly one cycle in CHECK_PARITY.
REQ-028 Header 8'h07 (addr 3) -> no wr_en, busy=0, state stays DECODE.
REQ-029 Addr 2, fifo_empty[2]=0 for 4 cycles -> busy=1, no write, header written the cycle after fifo_empty[2] rises; fifo_full[2] raised mid-payload for 3 cycles -> busy=1, held byte written once after release, none lost or duplicated.
REQ-030 SOFT_RST_TIMEOUT_EN defined, fifo_empty[0]=0, rd_en[0]=0 for 30 cycles -> soft_rst=3'b001 one cycle; rd_en[0] pulse at cycle 20 -> no soft_rst.
REQ-031 rst=0 asserted in LOAD_DATA -> next cycle state DECODE, all outputs 0; subsequent valid packet to addr 0 handled per REQ-026.

Source files
------------

// File: rtl/router_ctrl.sv
// router_ctrl: routes framed packets (header, payload, parity) from a byte
// source into one of three output FIFOs, with source back-pressure and a
// parity check per packet.
// Optional feature: define SOFT_RST_TIMEOUT_EN to enable the per-FIFO
// soft-reset timeout counters. Without it soft_rst is tied low.
module router_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [7:0] din,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] rd_en,
    output logic [2:0] wr_en,
    output logic [7:0] dout,
    output logic       lfd_state,
    output logic       busy,
    output logic       parity_err,
    output logic [2:0] soft_rst
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned NUM_FIFO = 3;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        DECODE       = 3'd0,
        WAIT_EMPTY   = 3'd1,
        LOAD_FIRST   = 3'd2,
        LOAD_DATA    = 3'd3,
        FIFO_FULL    = 3'd4,
        CHECK_PARITY = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   hdr_q, hdr_d;
    logic [DATA_W-1:0]   parity_q, parity_d;
    logic [DATA_W-1:0]   rx_parity_q, rx_parity_d;

    logic                full_sel;
    logic                empty_sel;
    logic                abort;
    logic                do_write;

    // Pick one bit of a per-FIFO status vector; address 3 never selects a FIFO.
    function automatic logic sel3(input logic [NUM_FIFO-1:0] vec,
                                  input logic [ADDR_W-1:0]   idx);
        logic bit_sel;
        case (idx)
            2'd0:    bit_sel = vec[0];
            2'd1:    bit_sel = vec[1];
            2'd2:    bit_sel = vec[2];
            default: bit_sel = 1'b0;
        endcase
        return bit_sel;
    endfunction

    // One-hot write enable for a FIFO address.
    function automatic logic [NUM_FIFO-1:0] onehot3(input logic [ADDR_W-1:0] idx);
        logic [NUM_FIFO-1:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Status of the FIFO addressed by the packet in flight.
    always_comb begin
        full_sel  = sel3(fifo_full, addr_q);
        empty_sel = sel3(fifo_empty, addr_q);
        abort     = 1'b0;
        if (state_q == WAIT_EMPTY || state_q == LOAD_FIRST ||
            state_q == LOAD_DATA  || state_q == FIFO_FULL) begin
            abort = sel3(soft_rst, addr_q);
        end
    end

    // Next-state logic and the zero-latency FIFO write path.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        hdr_d       = hdr_q;
        parity_d    = parity_q;
        rx_parity_d = rx_parity_q;
        do_write    = 1'b0;
        wr_en       = '0;
        dout        = '0;
        lfd_state   = 1'b0;
        busy        = 1'b0;
        parity_err  = 1'b0;

        case (state_q)
            DECODE: begin
                if (pkt_valid && (din[1:0] != ADDR_INVALID)) begin
                    addr_d   = din[1:0];
                    hdr_d    = din;
                    parity_d = din;
                    state_d  = sel3(fifo_empty, din[1:0]) ? LOAD_FIRST : WAIT_EMPTY;
                end
            end

            WAIT_EMPTY: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = DECODE;
                end else if (empty_sel) begin
                    state_d = LOAD_FIRST;
                end
            end

            LOAD_FIRST: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = DECODE;
                end else if (!full_sel) begin
                    // Header is held until the FIFO can take it.
                    do_write  = 1'b1;
                    dout      = hdr_q;
                    lfd_state = 1'b1;
                    state_d   = LOAD_DATA;
                end
            end

            LOAD_DATA: begin
                if (abort) begin
                    busy    = 1'b1;
                    state_d = DECODE;
                end else if (full_sel) begin
                    busy    = 1'b1;
                    state_d = FIFO_FULL;
                end else if (pkt_valid) begin
                    do_write = 1'b1;
                    dout     = din;
                    parity_d = parity_q ^ din;
                end else begin
                    // Low pkt_valid marks the parity byte; it is forwarded too.
                    do_write    = 1'b1;
                    dout        = din;
                    rx_parity_d = din;
                    state_d     = CHECK_PARITY;
                end
            end

            FIFO_FULL: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = DECODE;
                end else if (!full_sel) begin
                    state_d = LOAD_DATA;
                end
            end

            CHECK_PARITY: begin
                busy       = 1'b1;
                parity_err = (parity_q != rx_parity_q);
                state_d    = DECODE;
            end

            default: begin
                state_d = DECODE;
            end
        endcase

        if (do_write) begin
            wr_en = onehot3(addr_q);
        end
    end

    // FSM and packet context registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= DECODE;
            addr_q      <= '0;
            hdr_q       <= '0;
            parity_q    <= '0;
            rx_parity_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            hdr_q       <= hdr_d;
            parity_q    <= parity_d;
            rx_parity_q <= rx_parity_d;
        end
    end

`ifdef SOFT_RST_TIMEOUT_EN
    localparam int unsigned TMO_W      = 5;
    localparam int unsigned TMO_CYCLES = 30;

    logic [TMO_W-1:0]    tmo_cnt_q [NUM_FIFO];
    logic [TMO_W-1:0]    tmo_cnt_d [NUM_FIFO];
    logic [NUM_FIFO-1:0] soft_rst_q, soft_rst_d;

    // Count cycles a FIFO holds data nobody reads; fire a soft reset at the limit.
    always_comb begin
        for (int unsigned i = 0; i < NUM_FIFO; i++) begin
            tmo_cnt_d[i]  = '0;
            soft_rst_d[i] = 1'b0;
            if (!fifo_empty[i] && !rd_en[i]) begin
                if (tmo_cnt_q[i] == TMO_W'(TMO_CYCLES - 1)) begin
                    soft_rst_d[i] = 1'b1;
                end else begin
                    tmo_cnt_d[i] = tmo_cnt_q[i] + TMO_W'(1);
                end
            end
        end
    end

    // Timeout counter and soft-reset pulse registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_FIFO; i++) begin
                tmo_cnt_q[i] <= '0;
            end
            soft_rst_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_FIFO; i++) begin
                tmo_cnt_q[i] <= tmo_cnt_d[i];
            end
            soft_rst_q <= soft_rst_d;
        end
    end

    assign soft_rst = soft_rst_q;
`else
    logic unused_rd_en;

    // Read strobes only feed the timeout counters, which are absent here.
    assign unused_rd_en = ^rd_en;
    assign soft_rst     = '0;
`endif

endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl: directed packets against router_ctrl with a write/parity
// scoreboard checked by an independent monitor.
module tb_router_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       pkt_valid;
    logic [7:0] din;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] rd_en;
    logic [2:0] wr_en;
    logic [7:0] dout;
    logic       lfd_state;
    logic       busy;
    logic       parity_err;
    logic [2:0] soft_rst;

    router_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .pkt_valid  (pkt_valid),
        .din        (din),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .dout       (dout),
        .lfd_state  (lfd_state),
        .busy       (busy),
        .parity_err (parity_err),
        .soft_rst   (soft_rst)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] wr;
        logic [7:0] data;
        logic       lfd;
    } wr_exp_t;

    typedef logic [7:0] bytes_t[$];

    wr_exp_t exp_wr_q[$];
    logic    exp_par_q[$];
    int      checks   = 0;
    int      failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic bytes_t mk2(input logic [7:0] a, input logic [7:0] b);
        bytes_t q;
        q.push_back(a);
        q.push_back(b);
        return q;
    endfunction

    function automatic bytes_t mk3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        bytes_t q;
        q.push_back(a);
        q.push_back(b);
        q.push_back(c);
        return q;
    endfunction

    // Monitor: pops expected writes / parity results whenever the DUT presents them.
    logic    par_pending = 1'b0;
    wr_exp_t mon_e;
    always @(negedge clk) begin
        #2;
        if (par_pending) begin
            par_pending = 1'b0;
            if (exp_par_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL parity_check_unexpected: got parity_err=%0b expected=no packet", parity_err);
            end else begin
                check("parity_err", 32'(parity_err), 32'(exp_par_q.pop_front()));
            end
        end else begin
            check("parity_err_idle", 32'(parity_err), 32'(0));
        end
        if (wr_en !== 3'b000) begin
            check("wr_while_full", 32'(wr_en & fifo_full), 32'(0));
            if (exp_wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got wr_en=%b dout=%h expected=no write", wr_en, dout);
            end else begin
                mon_e = exp_wr_q.pop_front();
                check("write", 32'({wr_en, dout, lfd_state}), 32'({mon_e.wr, mon_e.data, mon_e.lfd}));
            end
            if (!pkt_valid) par_pending = 1'b1;
        end
    end

    // Present one byte and hold it while the DUT stalls the source.
    task automatic drive_byte(input logic v, input logic [7:0] d);
        int n;
        @(negedge clk);
        pkt_valid = v;
        din       = d;
        #2;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout: got busy=1 expected=0 within 100 cycles");
        end
    endtask

    task automatic send_packet(input logic [7:0] hdr, input bytes_t pl, input logic [7:0] par,
                               input logic [2:0] exp_wr, input logic exp_err);
        exp_wr_q.push_back(wr_exp_t'{exp_wr, hdr, 1'b1});
        foreach (pl[i]) exp_wr_q.push_back(wr_exp_t'{exp_wr, pl[i], 1'b0});
        exp_wr_q.push_back(wr_exp_t'{exp_wr, par, 1'b0});
        exp_par_q.push_back(exp_err);
        drive_byte(1'b1, hdr);
        foreach (pl[i]) drive_byte(1'b1, pl[i]);
        drive_byte(1'b0, par);
        @(negedge clk);
        pkt_valid = 1'b0;
        din       = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},      32'(wr_en),      32'(0));
        check({tag, "_dout"},       32'(dout),       32'(0));
        check({tag, "_lfd_state"},  32'(lfd_state),  32'(0));
        check({tag, "_busy"},       32'(busy),       32'(0));
        check({tag, "_parity_err"}, 32'(parity_err), 32'(0));
        check({tag, "_soft_rst"},   32'(soft_rst),   32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] seen;

        rst        = 1'b0;
        pkt_valid  = 1'b1;
        din        = 8'h0D;
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        rd_en      = 3'b000;
        repeat (3) @(negedge clk);
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst       = 1'b1;
        pkt_valid = 1'b0;
        din       = 8'h00;

        // Good packet to FIFO 1.
        send_packet(8'h0D, mk3(8'h11, 8'h22, 8'h33), 8'h0D, 3'b010, 1'b0);
        // Same packet with a corrupted parity byte.
        send_packet(8'h0D, mk3(8'h11, 8'h22, 8'h33), 8'hFF, 3'b010, 1'b1);

        // Address 3 header is dropped and the FSM stays in DECODE.
        @(negedge clk);
        pkt_valid = 1'b1;
        din       = 8'h07;
        #2;
        check("addr3_busy", 32'(busy), 32'(0));
        check("addr3_wr_en", 32'(wr_en), 32'(0));
        @(negedge clk);
        pkt_valid = 1'b0;
        din       = 8'h00;
        #2;
        check("addr3_next_busy", 32'(busy), 32'(0));
        check("addr3_next_wr_en", 32'(wr_en), 32'(0));

        // Packet to FIFO 0.
        send_packet(8'h08, mk2(8'hA5, 8'h5A), 8'hF7, 3'b001, 1'b0);

        // FIFO 2 not empty for 4 cycles, then full for 3 cycles mid-payload.
        fifo_empty[2] = 1'b0;
        fork
            send_packet(8'h0E, mk3(8'h01, 8'h02, 8'h04), 8'h09, 3'b100, 1'b0);
            begin
                @(negedge clk);
                for (int k = 1; k <= 4; k++) begin
                    @(negedge clk);
                    #2;
                    check("wait_empty_busy", 32'(busy), 32'(1));
                    check("wait_empty_wr_en", 32'(wr_en), 32'(0));
                end
                @(negedge clk);
                fifo_empty[2] = 1'b1;
                #2;
                check("empty_rise_no_write", 32'(wr_en), 32'(0));
                @(negedge clk);
                #2;
                check("hdr_after_empty", 32'({wr_en, dout, lfd_state}), 32'({3'b100, 8'h0E, 1'b1}));
                @(negedge clk);
                @(negedge clk);
                fifo_full[2] = 1'b1;
                for (int k = 1; k <= 3; k++) begin
                    #2;
                    check("full_busy", 32'(busy), 32'(1));
                    check("full_wr_en", 32'(wr_en), 32'(0));
                    if (k < 3) @(negedge clk);
                end
                @(negedge clk);
                fifo_full[2] = 1'b0;
                #2;
                check("release_busy", 32'(busy), 32'(1));
                check("release_wr_en", 32'(wr_en), 32'(0));
                @(negedge clk);
                #2;
                check("held_byte_write", 32'({wr_en, dout}), 32'({3'b100, 8'h02}));
            end
        join

        // Reset asserted while in LOAD_DATA.
        exp_wr_q.push_back(wr_exp_t'{3'b001, 8'h0C, 1'b1});
        exp_wr_q.push_back(wr_exp_t'{3'b001, 8'h3C, 1'b0});
        exp_wr_q.push_back(wr_exp_t'{3'b001, 8'hC3, 1'b0});
        drive_byte(1'b1, 8'h0C);
        drive_byte(1'b1, 8'h3C);
        @(negedge clk);
        pkt_valid = 1'b1;
        din       = 8'hC3;
        rst       = 1'b0;
        @(negedge clk);
        pkt_valid = 1'b0;
        din       = 8'h00;
        #2;
        check_all_zero("midpkt_reset");
        @(negedge clk);
        rst = 1'b1;
        send_packet(8'h0C, mk3(8'h11, 8'h22, 8'h33), 8'h0C, 3'b001, 1'b0);

`ifdef SOFT_RST_TIMEOUT_EN
        // 30 unread cycles on FIFO 0 fire one soft reset.
        @(negedge clk);
        fifo_empty[0] = 1'b0;
        seen = 3'b000;
        for (int k = 1; k <= 29; k++) begin
            @(negedge clk);
            #2;
            seen = seen | soft_rst;
        end
        check("soft_rst_early", 32'(seen), 32'(0));
        @(negedge clk);
        #2;
        check("soft_rst_timeout", 32'(soft_rst), 32'(3'b001));
        @(negedge clk);
        #2;
        check("soft_rst_one_cycle", 32'(soft_rst), 32'(0));
        @(negedge clk);
        fifo_empty[0] = 1'b1;
        repeat (2) @(negedge clk);
        // A read at cycle 20 restarts the count.
        fifo_empty[0] = 1'b0;
        seen = 3'b000;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            rd_en[0] = (k == 20);
            #2;
            seen = seen | soft_rst;
        end
        check("soft_rst_after_read", 32'(seen), 32'(0));
        fifo_empty[0] = 1'b1;
        rd_en         = 3'b000;
`else
        // Without the timeout feature soft_rst never pulses.
        @(negedge clk);
        fifo_empty[0] = 1'b0;
        seen = 3'b000;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            #2;
            seen = seen | soft_rst;
        end
        check("soft_rst_tied", 32'(seen), 32'(0));
        fifo_empty[0] = 1'b1;
`endif

        repeat (5) @(negedge clk);
        #3;
        check("write_queue_drained", 32'(exp_wr_q.size()), 32'(0));
        check("parity_queue_drained", 32'(exp_par_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
